// File: rtl/exe_result_queue.sv
// Show-ahead result/status FIFO behind the execution unit. Words that arrive
// while the FIFO is full are dropped and flagged. Sticky status and error count.
module exe_result_queue #(
  parameter int m     = 4,
  parameter int n     = 2,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rsn,
  input  logic                       i_valid,
  input  logic [n-1:0]               i_oper,
  input  logic [m-1:0]               i_result,
  input  logic [3:0]                 i_status,
  input  logic                       i_ready,
  input  logic                       i_clr,
  output logic                       o_valid,
  output logic [n-1:0]               o_oper,
  output logic [m-1:0]               o_result,
  output logic [3:0]                 o_status,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_overflow,
  output logic [3:0]                 o_status_sticky,
  output logic [CW-1:0]              o_err_cnt
);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int WW   = n + m + 4;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] ONE_CNT  = CNTW'(1);
  localparam logic [AW-1:0]   ONE_PTR  = AW'(1);
  localparam logic [CW-1:0]   ERR_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0]   ONE_ERR  = CW'(1);

  logic [WW-1:0]   mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CNTW-1:0] count_r;
  logic            overflow_r;
  logic [3:0]      sticky_r;
  logic [CW-1:0]   err_cnt_r;
  logic            valid_s;
  logic            full_s;
  logic            push_s;
  logic            pop_s;
  logic            drop_s;
  logic [WW-1:0]   head_s;

  assign valid_s = (count_r != {CNTW{1'b0}});
  assign full_s  = (count_r == FULL_CNT);
  assign pop_s   = valid_s & i_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push_s  = i_valid & (~full_s | pop_s);
  assign drop_s  = i_valid & full_s & ~pop_s;

  // Occupancy count and read/write pointers.
  always_ff @(posedge i_clk or posedge i_rsn) begin
    if (i_rsn) begin
      count_r  <= {CNTW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + ONE_PTR;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + ONE_PTR;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (push_s) mem_r[wr_ptr_r] <= {i_oper, i_result, i_status};
  end

  // Overflow flag, sticky status and saturating error count; clear wins.
  always_ff @(posedge i_clk or posedge i_rsn) begin
    if (i_rsn) begin
      overflow_r <= 1'b0;
      sticky_r   <= 4'h0;
      err_cnt_r  <= {CW{1'b0}};
    end else if (i_clr) begin
      overflow_r <= 1'b0;
      sticky_r   <= 4'h0;
      err_cnt_r  <= {CW{1'b0}};
    end else begin
      if (drop_s) overflow_r <= 1'b1;
      if (push_s) begin
        sticky_r <= sticky_r | i_status;
        if ((i_status != 4'h0) && (err_cnt_r != ERR_MAX)) err_cnt_r <= err_cnt_r + ONE_ERR;
      end
    end
  end

  // Head word, forced to zero while the queue is empty.
  always_comb begin
    head_s = {WW{1'b0}};
    if (valid_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = {WW{1'b0}};
    end
  end

  assign {o_oper, o_result, o_status} = head_s;
  assign o_valid         = valid_s;
  assign o_full          = full_s;
  assign o_count         = count_r;
  assign o_overflow      = overflow_r;
  assign o_status_sticky = sticky_r;
  assign o_err_cnt       = err_cnt_r;
endmodule

// File: tb/tb_exe_result_queue.sv
// Scoreboard bench for exe_result_queue: queue-based reference model, directed
// scenarios followed by randomized traffic; a second instance uses CW=2.
module tb_exe_result_queue;
  localparam int DEPTH = 4;

  logic       i_clk = 1'b0;
  logic       i_rsn = 1'b1;
  logic       i_valid = 1'b0;
  logic [1:0] i_oper = 2'b00;
  logic [3:0] i_result = 4'h0;
  logic [3:0] i_status = 4'h0;
  logic       i_ready = 1'b0;
  logic       i_clr = 1'b0;

  logic       o_valid, o_full, o_overflow;
  logic [1:0] o_oper;
  logic [3:0] o_result, o_status, o_status_sticky;
  logic [2:0] o_count;
  logic [7:0] o_err_cnt;

  logic       b_valid, b_full, b_overflow;
  logic [1:0] b_oper;
  logic [3:0] b_result, b_status, b_status_sticky;
  logic [2:0] b_count;
  logic [1:0] b_err_cnt;

  int checks = 0;
  int failures = 0;

  exe_result_queue #(.m(4), .n(2), .DEPTH(DEPTH), .CW(8)) dut (
    .i_clk(i_clk), .i_rsn(i_rsn), .i_valid(i_valid), .i_oper(i_oper),
    .i_result(i_result), .i_status(i_status), .i_ready(i_ready), .i_clr(i_clr),
    .o_valid(o_valid), .o_oper(o_oper), .o_result(o_result), .o_status(o_status),
    .o_count(o_count), .o_full(o_full), .o_overflow(o_overflow),
    .o_status_sticky(o_status_sticky), .o_err_cnt(o_err_cnt)
  );

  exe_result_queue #(.m(4), .n(2), .DEPTH(DEPTH), .CW(2)) dut_cw2 (
    .i_clk(i_clk), .i_rsn(i_rsn), .i_valid(i_valid), .i_oper(i_oper),
    .i_result(i_result), .i_status(i_status), .i_ready(i_ready), .i_clr(i_clr),
    .o_valid(b_valid), .o_oper(b_oper), .o_result(b_result), .o_status(b_status),
    .o_count(b_count), .o_full(b_full), .o_overflow(b_overflow),
    .o_status_sticky(b_status_sticky), .o_err_cnt(b_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue contents, occupancy and accounting.
  typedef struct packed {
    logic [1:0] oper;
    logic [3:0] result;
    logic [3:0] status;
  } word_t;

  word_t      exp_q[$];
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  logic [3:0] m_sticky = 4'h0;
  int         m_err = 0;
  int         m_err2 = 0;

  always @(posedge i_clk or posedge i_rsn) begin
    bit pop, push, drop;
    if (i_rsn) begin
      exp_q.delete();
      m_cnt    <= 0;
      m_ovf    <= 1'b0;
      m_sticky <= 4'h0;
      m_err    <= 0;
      m_err2   <= 0;
    end else begin
      pop  = (m_cnt > 0) && i_ready;
      push = i_valid && ((m_cnt < DEPTH) || pop);
      drop = i_valid && !push;
      if (push) exp_q.push_back('{oper: i_oper, result: i_result, status: i_status});
      m_cnt <= m_cnt + int'(push) - int'(pop);
      if (i_clr) begin
        m_ovf    <= 1'b0;
        m_sticky <= 4'h0;
        m_err    <= 0;
        m_err2   <= 0;
      end else begin
        if (drop) m_ovf <= 1'b1;
        if (push) begin
          m_sticky <= m_sticky | i_status;
          if (i_status != 4'h0) begin
            m_err  <= (m_err < 255) ? m_err + 1 : 255;
            m_err2 <= (m_err2 < 3) ? m_err2 + 1 : 3;
          end
        end
      end
    end
  end

  // Monitor: compares DUT outputs with the model and retires popped words.
  always @(negedge i_clk) begin
    chk("count", o_count, m_cnt);
    chk("valid", o_valid, m_cnt > 0);
    chk("full", o_full, m_cnt == DEPTH);
    chk("overflow", o_overflow, m_ovf);
    chk("sticky", o_status_sticky, m_sticky);
    chk("err_cnt", o_err_cnt, m_err);
    chk("err_cnt_cw2", b_err_cnt, m_err2);
    if (m_cnt > 0) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
        chk("head_oper", o_oper, exp_q[0].oper);
        chk("head_result", o_result, exp_q[0].result);
        chk("head_status", o_status, exp_q[0].status);
        if (i_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("empty_head", {o_oper, o_result, o_status}, 10'd0);
    end
  end

  task automatic step(input logic v, input logic [1:0] op, input logic [3:0] r,
                      input logic [3:0] s, input logic rdy, input logic clr);
    i_valid = v; i_oper = op; i_result = r; i_status = s; i_ready = rdy; i_clr = clr;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [3:0] drain_exp [4];
    repeat (3) @(posedge i_clk);
    #1 i_rsn = 1'b0;

    // Idle after reset.
    step(1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("rst_valid", o_valid, 32'd0);
    chk("rst_count", o_count, 32'd0);
    chk("rst_head", {o_oper, o_result, o_status}, 32'd0);
    chk("rst_ovf", o_overflow, 32'd0);
    chk("rst_sticky", o_status_sticky, 32'd0);
    chk("rst_err", o_err_cnt, 32'd0);

    // Single word: visible after the push edge, popped next cycle.
    step(1'b1, 2'b01, 4'hA, 4'h0, 1'b1, 1'b0);
    chk("single_valid", o_valid, 32'd1);
    chk("single_result", o_result, 32'hA);
    chk("single_oper", o_oper, 32'h1);
    step(1'b0, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("single_count", o_count, 32'd0);
    chk("single_err", o_err_cnt, 32'd0);

    // Fill past DEPTH without draining.
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 2'b10, 4'(i), 4'h0, 1'b0, 1'b0);
      if (i == 4) chk("fill_full", o_full, 32'd1);
    end
    chk("fill_ovf", o_overflow, 32'd1);
    chk("fill_count", o_count, 32'd4);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_order", o_result, k);
      step(1'b0, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    end
    chk("drain_empty", o_count, 32'd0);
    step(1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("clr_ovf", o_overflow, 32'd0);

    // Full queue with simultaneous push and pop.
    for (int i = 6; i <= 9; i++) step(1'b1, 2'b00, 4'(i), 4'h0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 4'hB, 4'h0, 1'b1, 1'b0);
    chk("fullpp_count", o_count, 32'd4);
    chk("fullpp_ovf", o_overflow, 32'd0);
    drain_exp[0] = 4'h7; drain_exp[1] = 4'h8; drain_exp[2] = 4'h9; drain_exp[3] = 4'hB;
    for (int k = 0; k < 4; k++) begin
      chk("fullpp_order", o_result, drain_exp[k]);
      step(1'b0, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    end

    // Status accounting and clear priority.
    step(1'b1, 2'b00, 4'h1, 4'h1, 1'b1, 1'b0);
    step(1'b1, 2'b00, 4'h2, 4'h4, 1'b1, 1'b0);
    step(1'b1, 2'b00, 4'h3, 4'h0, 1'b1, 1'b0);
    chk("acct_sticky", o_status_sticky, 32'h5);
    chk("acct_err", o_err_cnt, 32'd2);
    step(1'b1, 2'b00, 4'h4, 4'h8, 1'b0, 1'b1);
    chk("clr_sticky", o_status_sticky, 32'h0);
    chk("clr_err", o_err_cnt, 32'd0);
    chk("clr_count", o_count, 32'd2);
    chk("clr_head_status", o_status, 32'h0);
    repeat (2) step(1'b0, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0);

    // Error-count saturation on the CW=2 instance.
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 4'(i), 4'h2, 1'b1, 1'b0);
    chk("sat_cw2", b_err_cnt, 32'd3);
    chk("sat_cw8", o_err_cnt, 32'd5);
    step(1'b0, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0);

    // Asynchronous reset with two entries queued.
    step(1'b1, 2'b00, 4'hC, 4'h0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 4'hD, 4'h0, 1'b0, 1'b0);
    chk("prerst_count", o_count, 32'd2);
    i_rsn = 1'b1;
    #1;
    chk("async_rst_count", o_count, 32'd0);
    chk("async_rst_valid", o_valid, 32'd0);
    @(negedge i_clk);
    #2 i_rsn = 1'b0;
    step(1'b0, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("postrst_count", o_count, 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) < 7, 2'($urandom), 4'($urandom),
           ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
           $urandom_range(0, 9) < 5, $urandom_range(0, 49) == 0);
    end
    repeat (6) step(1'b0, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("final_empty", o_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exe_result_queue.md
Name: exe_result_queue

Overview:
- Downstream stage of the 2-bit-opcode execution unit. Captures each registered result/status word that unit produces, tagged with its opcode.
- Buffers the words in a small show-ahead FIFO and presents them to a consumer over a valid/ready handshake.
- The execution unit cannot stall, so words arriving while the queue is full are dropped and flagged.
- Also keeps a sticky OR of all status bits and a saturating count of results with non-zero status.

Parameters:
- m, 4, result data width (matches execution unit m)
- n, 2, opcode width (matches execution unit n)
- DEPTH, 4, FIFO entries; power of two, >= 2
- CW, 8, error-counter width

Ports:
- i_clk  input  1  clock; all state updates on its rising edge
- i_rsn  input  1  reset, asynchronous, active-high (1 = reset asserted despite the name)
- i_valid  input  1  execution-unit output word valid this cycle
- i_oper  input  n  opcode that produced the word (registered alongside the result upstream)
- i_result  input  m  execution-unit o_result
- i_status  input  4  execution-unit o_status
- i_ready  input  1  consumer accepts head entry this cycle
- i_clr  input  1  synchronous clear of sticky status, overflow flag and error counter
- o_valid  output  1  head entry available
- o_oper  output  n  head entry opcode
- o_result  output  m  head entry result
- o_status  output  4  head entry status
- o_count  output  $clog2(DEPTH+1)  occupied entries
- o_full  output  1  count == DEPTH
- o_overflow  output  1  sticky: at least one word dropped
- o_status_sticky  output  4  OR of i_status over all accepted words
- o_err_cnt  output  CW  accepted words with i_status != 0, saturating

Behaviour:
- Reset (async assert, sync release):
  - o_count, pointers, o_overflow, o_status_sticky, o_err_cnt = 0.
  - o_valid = 0, o_full = 0.
  - o_oper/o_result/o_status = 0; storage array not reset, but head outputs are forced to 0 while empty.
- Reset mid-operation discards all queued entries immediately; nothing is recovered after release.
- pop = o_valid & i_ready.
- push = i_valid & (!o_full | pop). When full, a simultaneous pop frees the slot for the push.
- drop = i_valid & o_full & !pop. On drop: the word is discarded and o_overflow is set; o_status_sticky and o_err_cnt are not updated.
- Latency:
  - A word pushed at edge k is visible at the outputs after edge k; o_valid rises in the following cycle.
  - No same-cycle bypass from input to output.
- Show-ahead: o_oper/o_result/o_status always reflect the head entry while o_valid = 1 and are held stable until popped.
- Count update:
  - push & !pop: +1
  - pop & !push: -1
  - both or neither: unchanged
- Push with count == 0 and i_ready = 1 in the same cycle: no pop (o_valid = 0); the entry is stored.
- Pointers wrap modulo DEPTH. o_full = (o_count == DEPTH). o_valid = (o_count != 0).
- Accounting on push:
  - o_status_sticky |= i_status.
  - If i_status != 0, o_err_cnt increments, holding at 2^CW-1.
- i_clr = 1:
  - Next cycle o_overflow, o_status_sticky and o_err_cnt = 0.
  - Clear has priority: accounting for a push or drop in the same cycle is lost.
  - The FIFO contents and handshake are unaffected.
- i_ready while o_valid = 0 is ignored. i_valid is sampled every cycle; there is no backpressure to the upstream unit.

Test Plan:
- Reset then idle -> all outputs 0, o_valid = 0. Assert i_rsn mid-cycle with 2 entries queued -> o_count = 0 immediately, before the next edge.
- Push oper=2'b01 result=4'hA status=4'h0, i_ready=1 -> o_valid = 1 one cycle later with o_result = 4'hA; popped that cycle; o_count returns to 0; o_err_cnt = 0.
- i_ready=0, push 5 words with results 1,2,3,4,5 (DEPTH = 4):
  - o_full = 1 after 4 pushes; 5th is dropped and o_overflow = 1.
  - Draining yields 1,2,3,4 in order.
- Full queue with i_valid=1 and i_ready=1 in the same cycle -> head pops, new word stored, o_count stays 4, o_overflow stays 0.
- Push statuses 4'h1, 4'h4, 4'h0 -> o_status_sticky = 4'h5, o_err_cnt = 2. Pulse i_clr together with a push of status 4'h8 -> sticky = 0, o_err_cnt = 0, but the word is still queued.
- With CW=2, push 5 words with status 4'h2 while draining -> o_err_cnt saturates at 3.
